// File: rtl/reg_bus_pkg.sv
// Shared types and sizing helpers for the register-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_CAPT, RD_WAIT} rb_state_e;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 16;

  // The timeout counter only ever holds 0..timeout-1, so clog2(timeout) bits suffice.
  function automatic int tmo_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/reg_bus_arb_if.sv
// Register-bus link between the arbiter (master) and the shared register slave.
// Latency: n/a (wires only).
// Backpressure: slave paces transfers with ready; master holds sel/wr/addr/wdata until done.
// Ports: sel, wr, addr, wdata (master->slave); rdata, ready (slave->master).
interface reg_bus_arb_if import reg_bus_pkg::*; #(
  parameter int ADDR_WIDTH = RB_ADDR_W,
  parameter int DATA_WIDTH = RB_DATA_W
) ();

  logic                  sel;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output sel, wr, addr, wdata, input rdata, ready);
  modport slave  (input sel, wr, addr, wdata, output rdata, ready);

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester searching upward from rr_last+1.
// Latency: combinational.
// Backpressure: none; caller masks the eligible vector.
// Ports: eligible, rr_last in; grant (one-hot), grant_idx, any out.
module rr_pick import reg_bus_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // k=1 first so the previous winner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!any && eligible[IDX_W'(idx)]) begin
        any                   = 1'b1;
        grant[IDX_W'(idx)]    = 1'b1;
        grant_idx             = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter/sequencer sharing one register slave between NUM_REQ requesters.
// Latency: write ack 2 edges after req is seen, read ack 3 edges; all outputs registered.
// Backpressure: waits on slave ready up to TIMEOUT cycles, then acks with ack_err.
// Ports: clk, rstn; req/req_wr/req_addr/req_wdata in; ack/ack_err/ack_rdata out; m (slave bus).
module reg_bus_arb import reg_bus_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = RB_ADDR_W,
  parameter int DATA_WIDTH = RB_DATA_W,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          ack_err,
  output logic [DATA_WIDTH-1:0]         ack_rdata,
  reg_bus_arb_if.master                 m
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = tmo_w(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  rb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]      rr_last_q, rr_last_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sel_q, sel_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  // A requester being acked this cycle still has req high; masking it avoids a double grant.
  assign eligible = req & ~ack_q;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible  (eligible),
    .rr_last   (rr_last_q),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_last_q <= IDX_W'(NUM_REQ - 1);
      tmo_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    tmo_d     = tmo_q;
    ack_d     = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
              wr_d    = req_wr[i];
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          gnt_d     = pick_oh;
          rr_last_d = pick_idx;
          tmo_d     = '0;
          sel_d     = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m.ready) begin
          if (wr_q) begin
            ack_d   = gnt_q;
            rdata_d = '0;
            sel_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RD_CAPT;
          end
        end else if (tmo_q == TMO_LAST) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          rdata_d = '0;
          sel_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RD_CAPT: begin
        // Data is valid the cycle after acceptance; sel stays up through the slave's recovery.
        rdata_d = m.rdata;
        ack_d   = gnt_q;
        tmo_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Requester already has its ack, so a recovery timeout just releases the bus.
        if (m.ready || tmo_q == TMO_LAST) begin
          sel_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack       = ack_q;
  assign ack_err   = err_q;
  assign ack_rdata = rdata_q;
  assign m.sel     = sel_q;
  assign m.wr      = wr_q;
  assign m.addr    = addr_q;
  assign m.wdata   = wdata_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb with a behavioural register slave (reset value 16'h1507).
module tb_reg_bus_arb;

  localparam int NR  = 2;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req       = '0;
  logic [NR-1:0]    req_wr    = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    ack;
  logic             ack_err;
  logic [DW-1:0]    ack_rdata;

  int vectors     = 0;
  int miscompares = 0;

  reg_bus_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_bus_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .ack_err   (ack_err),
    .ack_rdata (ack_rdata),
    .m         (bus)
  );

  always #5 clk = ~clk;

  // Register slave: writes land on the accept edge; reads present data next cycle and
  // hold ready low for two cycles, restoring it only while sel is high. The edge on which
  // the master sees ready restored is not a new transfer.
  logic [DW-1:0] mem [256];
  logic          s_ready, s_rec, s_hold;
  logic [DW-1:0] s_rdata;
  logic          stuck = 1'b0;

  assign bus.ready = s_ready;
  assign bus.rdata = s_rdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ready <= 1'b1;
      s_rec   <= 1'b0;
      s_hold  <= 1'b0;
      s_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1507;
    end else if (stuck) begin
      s_ready <= 1'b0;
    end else if (s_hold) begin
      s_hold <= 1'b0;
    end else if (bus.sel && s_ready) begin
      if (bus.wr) begin
        mem[bus.addr] <= bus.wdata;
      end else begin
        s_rdata <= mem[bus.addr];
        s_ready <= 1'b0;
        s_rec   <= 1'b1;
      end
    end else if (bus.sel && !s_ready) begin
      if (s_rec) s_rec <= 1'b0;
      else begin
        s_ready <= 1'b1;
        s_hold  <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int       rem0, rem1, nacks, cyc, nsel, nack, n;
  logic     psel;
  logic [1:0] exp_g;

  initial begin
    // Reset values
    rstn = 1'b0;
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_err", ack_err, 0);
    chk("rst_rdata", ack_rdata, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    rstn = 1'b1;
    tick();

    // T1: req0 read 0x10 -> reset value, sel high for 4 cycles
    req = 2'b01; req_wr = 2'b00; req_addr[0 +: AW] = 8'h10;
    tick();
    chk("t1_sel_e0", bus.sel, 1);
    chk("t1_addr", bus.addr, 8'h10);
    chk("t1_wr", bus.wr, 0);
    chk("t1_ack_e0", ack, 0);
    tick();
    chk("t1_ack_e1", ack, 0);
    chk("t1_sel_e1", bus.sel, 1);
    tick();
    chk("t1_ack", ack, 2'b01);
    chk("t1_rdata", ack_rdata, 16'h1507);
    chk("t1_err", ack_err, 0);
    req = 2'b00;
    tick();
    chk("t1_ack_pulse", ack, 0);
    chk("t1_sel_e3", bus.sel, 1);
    tick();
    chk("t1_sel_e4", bus.sel, 0);
    chk("t1_rdata_hold", ack_rdata, 16'h1507);

    // T2: req0 writes 0x22<=BEEF, then req1 reads it back
    req = 2'b01; req_wr = 2'b01; req_addr[0 +: AW] = 8'h22; req_wdata[0 +: DW] = 16'hBEEF;
    tick();
    chk("t2_sel", bus.sel, 1);
    chk("t2_wr", bus.wr, 1);
    chk("t2_wdata", bus.wdata, 16'hBEEF);
    tick();
    chk("t2_wack", ack, 2'b01);
    chk("t2_wrdata", ack_rdata, 0);
    chk("t2_werr", ack_err, 0);
    req = 2'b10; req_wr = 2'b00; req_addr[AW +: AW] = 8'h22;
    tick();
    chk("t2_rsel", bus.sel, 1);
    chk("t2_raddr", bus.addr, 8'h22);
    chk("t2_rwr", bus.wr, 0);
    tick(); tick();
    chk("t2_rack", ack, 2'b10);
    chk("t2_rdata", ack_rdata, 16'hBEEF);
    req = 2'b00;
    tick(); tick();
    chk("t2_sel_end", bus.sel, 0);

    // T3: both requesters hold req for 4 writes each -> strict alternation, 2 cycles per write
    rem0 = 4; rem1 = 4; nacks = 0; cyc = 0; exp_g = 2'b01;
    req_wr = 2'b11; req_addr = {8'h40, 8'h30}; req_wdata = {16'hB000, 16'hA000};
    req = 2'b11;
    while (nacks < 8 && cyc < 40) begin
      tick();
      cyc++;
      if (ack != 2'b00) begin
        chk($sformatf("t3_grant%0d", nacks), ack, exp_g);
        exp_g = ~exp_g;
        nacks++;
        if (ack[0]) begin
          rem0--;
          if (rem0 == 0) req[0] = 1'b0;
          else begin
            req_addr[0 +: AW]  = req_addr[0 +: AW] + 8'd1;
            req_wdata[0 +: DW] = req_wdata[0 +: DW] + 16'd1;
          end
        end
        if (ack[1]) begin
          rem1--;
          if (rem1 == 0) req[1] = 1'b0;
          else begin
            req_addr[AW +: AW]  = req_addr[AW +: AW] + 8'd1;
            req_wdata[DW +: DW] = req_wdata[DW +: DW] + 16'd1;
          end
        end
      end
    end
    chk("t3_nacks", nacks, 8);
    chk("t3_cycles", cyc, 16);
    chk("t3_mem0", mem[8'h33], 16'hA003);
    chk("t3_mem1", mem[8'h43], 16'hB003);
    req = 2'b00;
    tick();

    // T4: req dropped right after grant -> one transfer, one ack, no re-issue
    req = 2'b01; req_wr = 2'b01; req_addr[0 +: AW] = 8'h50; req_wdata[0 +: DW] = 16'h1234;
    tick();
    chk("t4_sel", bus.sel, 1);
    req = 2'b00;
    nsel = 0; nack = 0; psel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.sel && !psel) nsel++;
      psel = bus.sel;
      if (ack[0]) nack++;
    end
    chk("t4_nack", nack, 1);
    chk("t4_nsel", nsel, 0);
    chk("t4_mem", mem[8'h50], 16'h1234);

    // T5: reset during RD_WAIT -> outputs clear at once, no ack, slave back to reset value
    req = 2'b01; req_wr = 2'b00; req_addr[0 +: AW] = 8'h22;
    tick(); tick(); tick();
    chk("t5_ack", ack, 2'b01);
    chk("t5_rdata", ack_rdata, 16'hBEEF);
    req = 2'b00;
    tick();
    chk("t5_wait_sel", bus.sel, 1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_sel", bus.sel, 0);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_rdata", ack_rdata, 0);
    chk("t5_rst_wdata", bus.wdata, 0);
    chk("t5_rst_addr", bus.addr, 0);
    tick();
    chk("t5_rst_noack", ack, 0);
    rstn = 1'b1;
    tick();
    req = 2'b01; req_wr = 2'b00; req_addr[0 +: AW] = 8'h22;
    tick(); tick(); tick();
    chk("t5_post_ack", ack, 2'b01);
    chk("t5_post_rdata", ack_rdata, 16'h1507);
    req = 2'b00;
    tick(); tick();

    // T6: slave never ready -> error ack exactly TIMEOUT cycles after sel rises
    stuck = 1'b1;
    tick();
    req = 2'b01; req_wr = 2'b01; req_addr[0 +: AW] = 8'h60; req_wdata[0 +: DW] = 16'h5555;
    tick();
    chk("t6_sel", bus.sel, 1);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ack != 2'b00) break;
    end
    chk("t6_tmo_cycles", n, TMO);
    chk("t6_ack", ack, 2'b01);
    chk("t6_err", ack_err, 1);
    chk("t6_rdata", ack_rdata, 0);
    chk("t6_sel_drop", bus.sel, 0);
    req = 2'b00;
    tick();
    chk("t6_err_pulse", ack_err, 0);
    chk("t6_ack_pulse", ack, 0);
    chk("t6_sel_idle", bus.sel, 0);
    stuck = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
